// File: rtl/rr_decode_sched.sv
// Round-robin scheduler sharing one 4-to-16 decoder among 16 requesters.
// Grants are held until release, withdrawal or the hold limit, then one dead cycle follows.
module rr_decode_sched #(
  parameter int HOLD_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        done,
  output logic [3:0]  sel,
  output logic        en,
  output logic [15:0] gnt,
  output logic        busy,
  output logic        timeout
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic [7:0] CNT_LAST = 8'(HOLD_MAX - 1);

  logic [1:0] state;
  logic [3:0] last;
  logic [7:0] cnt;
  logic       win_valid;
  logic [3:0] win_idx;
  logic [3:0] idx;
  logic       hold_hit;
  logic       grant_end;

  // Scan from the farthest offset down to last+1 so the nearest requester
  // overwrites; offset 16 wraps onto the pointer itself, which is checked last.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = 4'd0;
    idx       = 4'd0;
    for (int k = 16; k >= 1; k--) begin
      idx = last + 4'(k);
      if (req[idx]) begin
        win_valid = 1'b1;
        win_idx   = idx;
      end
    end
  end

  assign hold_hit  = (cnt == CNT_LAST);
  assign grant_end = done | ~req[sel] | hold_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      sel     <= 4'd0;
      en      <= 1'b0;
      gnt     <= 16'd0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      last    <= 4'd15;
      cnt     <= 8'd0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_GRANT: begin
          if (grant_end) begin
            state   <= ST_GAP;
            last    <= sel;
            en      <= 1'b0;
            gnt     <= 16'd0;
            // Only a pure limit expiry counts as a timeout.
            timeout <= ~done & req[sel];
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          if (win_valid) begin
            state <= ST_GRANT;
            sel   <= win_idx;
            en    <= 1'b1;
            gnt   <= 16'd1 << win_idx;
            busy  <= 1'b1;
            cnt   <= 8'd0;
          end else begin
            state <= ST_IDLE;
            en    <= 1'b0;
            gnt   <= 16'd0;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/rr_decode_sched.md
Name: rr_decode_sched

Overview:
- Round-robin scheduler that shares one 4-to-16 decoder among 16 requesters.
- Picks one requester at a time and drives the decoder's 4-bit select and enable.
- Holds each grant until the requester releases it or a hold limit expires, then inserts one dead cycle before the next grant.
- Sits directly upstream of the decoder instance; also exports a registered one-hot grant vector for local use.

Parameters:
- HOLD_MAX, 8: maximum grant length in cycles; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset; sampled on the rising edge of clk
- req  input  16  request lines; req[i] high means requester i wants the decoder
- done  input  1  current grantee releases the grant; ignored outside GRANT
- sel  output  4  decoder select {A,B,C,D}, MSB = A; index of the current grantee
- en  output  1  decoder enable; high only in GRANT
- gnt  output  16  one-hot grant, gnt[sel] = 1 in GRANT; all zeros otherwise
- busy  output  1  high in GRANT or GAP
- timeout  output  1  one-cycle pulse when a grant is ended by the hold limit

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-low on rst_n. All outputs are registered.
- Reset values: state=IDLE, sel=0, en=0, gnt=0, busy=0, timeout=0, last-grant pointer=15, hold counter=0.
- Reset mid-operation: while rst_n=0, outputs take their reset values at the next edge regardless of state. No partial grant survives.
- States: IDLE, GRANT, GAP.
- Arbitration, evaluated in IDLE and GAP on the current req:
  - Winner = first i with req[i]=1, searching last+1, last+2, ... mod 16 (wrap 15 -> 0).
  - The last-grant pointer itself is checked last.
  - If req=0, there is no winner.
- IDLE:
  - winner -> GRANT next cycle, with sel=winner, en=1, gnt=one-hot(winner), busy=1, counter=0.
  - Otherwise stay in IDLE.
- GRANT, ends at the edge where any of the following is true:
  - done=1;
  - req[sel]=0 (requester withdrew);
  - counter = HOLD_MAX-1.
- GRANT otherwise: counter increments by 1.
- GRANT exit:
  - Next state GAP; last pointer <= sel.
  - en=0, gnt=0; sel holds its value; busy stays 1.
  - timeout=1 for exactly the first GAP cycle, only if the exit was caused solely by the counter (done=0 and req[sel]=1). If done or withdrawal coincides with the limit, timeout=0.
- GAP: lasts exactly one cycle.
  - winner -> GRANT; sel, en, gnt, busy and counter are loaded exactly as in IDLE.
  - No winner -> IDLE with busy=0.
- Latency:
  - req rising in IDLE at edge N -> en=1 after edge N+1.
  - Back-to-back grants are separated by exactly one en=0 cycle.
- Fairness: with all 16 requesting continuously, grants go 0,1,...,15,0,... in order; each grant lasts HOLD_MAX cycles.
- HOLD_MAX=1: every grant lasts one cycle and ends with timeout=1 unless done or withdrawal is present.
- Widths:
  - Hold counter is 8 bits and never exceeds HOLD_MAX-1.
  - Pointer arithmetic is modulo 16.
- Invariant: gnt is all zeros or exactly one-hot, and gnt ≠ 0 if and only if en=1.
- done while not in GRANT: no effect.
- req changes for non-granted lines during GRANT: no effect until the next arbitration.

Test Plan:
1. Reset and single request:
   - rst_n=0 for 2 cycles, then req=16'h0010 held, done=0, HOLD_MAX=8.
   - Required: sel=4, en=1, gnt=16'h0010 starting one cycle after req.
   - Lasts 8 cycles, then GAP with timeout=1.
   - Then sel=4 is re-granted after the single dead cycle.
2. Rotation: req=16'hFFFF held, done pulsed on the 3rd cycle of each grant.
   - Required: grant order 0,1,2,...,15,0; each en=1 run is 3 cycles; one en=0 cycle between grants; timeout never asserted.
3. Wrap and skip: last grant was 14, then req=16'h0003.
   - Required: next sel=0, then sel=1, then sel=0.
4. Withdrawal: grant on sel=7, req[7] dropped on the 2nd GRANT cycle.
   - Required: GAP follows at the next edge; timeout=0; with req=0, state returns to IDLE with busy=0.
5. Coincidence: HOLD_MAX=4, done=1 asserted on the 4th grant cycle.
   - Required: grant ends after 4 cycles with timeout=0.
6. Reset mid-grant: rst_n=0 during GRANT on sel=9.
   - Required: next edge gives en=0, gnt=0, sel=0, busy=0.
   - After release with req=16'h0200, the grant goes to 9, since the pointer was reset to 15 and the search starts at 0.
